// File: rtl/vram_access_arbiter_if.sv
// Signal bundle between the VRAM arbiter and its clients / the VRAM port.
// slave = arbiter side, master = requesters plus the VRAM array.
interface vram_access_arbiter_if #(
    parameter int VRAM_ADDR_WIDTH  = 14,
    parameter int VRAM_DATA_WIDTH  = 8,
    parameter int WFIFO_DEPTH_LOG2 = 2
);
    logic                         bkg_en;
    logic [VRAM_ADDR_WIDTH-1:0]   bkg_addr;
    logic [VRAM_DATA_WIDTH-1:0]   bkg_rdata;
    logic                         bkg_rvalid;

    logic                         spr_req;
    logic [VRAM_ADDR_WIDTH-1:0]   spr_addr;
    logic                         spr_grant;
    logic [VRAM_DATA_WIDTH-1:0]   spr_rdata;
    logic                         spr_rvalid;

    logic                         s_valid;
    logic [VRAM_ADDR_WIDTH-1:0]   s_addr;
    logic [VRAM_DATA_WIDTH-1:0]   s_data;
    logic                         s_ready;

    logic                         mem_en;
    logic                         mem_we;
    logic [VRAM_ADDR_WIDTH-1:0]   mem_addr;
    logic [VRAM_DATA_WIDTH-1:0]   mem_wdata;
    logic [VRAM_DATA_WIDTH-1:0]   mem_rdata;

    logic [WFIFO_DEPTH_LOG2:0]    wfifo_level;

    modport slave (
        input  bkg_en, bkg_addr, spr_req, spr_addr, s_valid, s_addr, s_data, mem_rdata,
        output bkg_rdata, bkg_rvalid, spr_grant, spr_rdata, spr_rvalid, s_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, wfifo_level
    );

    modport master (
        output bkg_en, bkg_addr, spr_req, spr_addr, s_valid, s_addr, s_data, mem_rdata,
        input  bkg_rdata, bkg_rvalid, spr_grant, spr_rdata, spr_rvalid, s_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, wfifo_level
    );
endinterface

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM arbiter: background reads always win, buffered bus writes
// and sprite reads share the remaining cycles with an anti-starvation counter.
module vram_access_arbiter #(
    parameter int VRAM_ADDR_WIDTH  = 14,
    parameter int VRAM_DATA_WIDTH  = 8,
    parameter int WFIFO_DEPTH_LOG2 = 2,
    parameter int WRITE_MAX_WAIT   = 15
) (
    input  logic                   clk,
    input  logic                   aresetn,
    vram_access_arbiter_if.slave   bus
);
    localparam int DEPTH = 1 << WFIFO_DEPTH_LOG2;
    localparam int LVLW  = WFIFO_DEPTH_LOG2 + 1;
    localparam int WCW   = (WRITE_MAX_WAIT < 1) ? 1 : $clog2(WRITE_MAX_WAIT + 1);

    typedef enum logic [1:0] {TAG_NONE, TAG_BKG, TAG_SPR} rd_tag_e;
    typedef enum logic [1:0] {SEL_IDLE, SEL_BKG, SEL_WR, SEL_SPR} sel_e;

    logic [VRAM_ADDR_WIDTH-1:0]  fifo_addr_q [DEPTH];
    logic [VRAM_DATA_WIDTH-1:0]  fifo_data_q [DEPTH];
    logic [WFIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [WFIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]             level_q, level_d;
    logic [WCW-1:0]              wait_cnt_q, wait_cnt_d;
    rd_tag_e                     rd_tag_q, rd_tag_d;
    sel_e                        sel;
    logic                        fifo_ne, wait_full, push, pop;

    // s_ready depends only on registered level, so s_valid never loops back into it.
    assign bus.s_ready     = (level_q != LVLW'(DEPTH));
    assign bus.wfifo_level = level_q;
    assign bus.bkg_rdata   = bus.mem_rdata;
    assign bus.spr_rdata   = bus.mem_rdata;
    assign bus.bkg_rvalid  = (rd_tag_q == TAG_BKG);
    assign bus.spr_rvalid  = (rd_tag_q == TAG_SPR);
    assign bus.spr_grant   = (sel == SEL_SPR);
    assign bus.mem_en      = (sel != SEL_IDLE);
    assign bus.mem_we      = (sel == SEL_WR);
    assign bus.mem_wdata   = fifo_data_q[rd_ptr_q];

    always_comb begin
        fifo_ne   = (level_q != '0);
        wait_full = (wait_cnt_q == WCW'(WRITE_MAX_WAIT));
        if (bus.bkg_en)               sel = SEL_BKG;
        else if (fifo_ne && wait_full) sel = SEL_WR;
        else if (bus.spr_req)          sel = SEL_SPR;
        else if (fifo_ne)              sel = SEL_WR;
        else                           sel = SEL_IDLE;
    end

    always_comb begin
        bus.mem_addr = '0;
        rd_tag_d     = TAG_NONE;
        case (sel)
            SEL_BKG: begin
                bus.mem_addr = bus.bkg_addr;
                rd_tag_d     = TAG_BKG;
            end
            SEL_SPR: begin
                bus.mem_addr = bus.spr_addr;
                rd_tag_d     = TAG_SPR;
            end
            SEL_WR:  bus.mem_addr = fifo_addr_q[rd_ptr_q];
            default: ;
        endcase
    end

    always_comb begin
        push     = bus.s_valid && bus.s_ready;
        pop      = (sel == SEL_WR);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + LVLW'(push) - LVLW'(pop);
        // Counter only measures how long the current head has been passed over.
        if (!fifo_ne || pop)  wait_cnt_d = '0;
        else if (!wait_full)  wait_cnt_d = wait_cnt_q + 1'b1;
        else                  wait_cnt_d = wait_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.s_addr;
            fifo_data_q[wr_ptr_q] <= bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wait_cnt_q <= '0;
            rd_tag_q   <= TAG_NONE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wait_cnt_q <= wait_cnt_d;
            rd_tag_q   <= rd_tag_d;
        end
    end
endmodule

// File: tb/tb_vram_access_arbiter.sv
// Randomized and directed checks of vram_access_arbiter against a queue-based
// reference model; the VRAM array is modelled here with 1-cycle read latency.
module tb_vram_access_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int L2   = 2;
    localparam int MAXW = 3;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    vram_access_arbiter_if #(.VRAM_ADDR_WIDTH(AW), .VRAM_DATA_WIDTH(DW), .WFIFO_DEPTH_LOG2(L2)) bus ();

    vram_access_arbiter #(
        .VRAM_ADDR_WIDTH(AW), .VRAM_DATA_WIDTH(DW),
        .WFIFO_DEPTH_LOG2(L2), .WRITE_MAX_WAIT(MAXW)
    ) dut (.clk(clk), .aresetn(aresetn), .bus(bus));

    // Contents stored as delta from the default pattern addr^0x5A so zero-init works.
    bit [7:0] vram_delta [1 << AW];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) vram_delta[bus.mem_addr] <= bus.mem_wdata ^ bus.mem_addr[7:0] ^ 8'h5A;
            else            bus.mem_rdata <= vram_delta[bus.mem_addr] ^ bus.mem_addr[7:0] ^ 8'h5A;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int qa[$];
    int qd[$];
    int wait_m = 0;
    int tag_m = 0;          // 0 none, 1 background, 2 sprite
    int last_win = 0;       // 0 idle, 1 bkg, 2 write, 3 sprite
    logic [7:0] rd_exp = '0;
    bit [7:0] shadow_delta [1 << AW];
    bit spr_pend = 0;
    int spr_pend_addr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_m(input int a);
        logic [AW-1:0] a14;
        a14 = AW'(a);
        return shadow_delta[a14] ^ a14[7:0] ^ 8'h5A;
    endfunction

    task automatic step(input bit be, input int ba, input bit sr, input int sa,
                        input bit sv, input int wa, input int wd);
        bit ne, rdy;
        int win;
        @(negedge clk);
        bus.bkg_en = be;  bus.bkg_addr = AW'(ba);
        bus.spr_req = sr; bus.spr_addr = AW'(sa);
        bus.s_valid = sv; bus.s_addr = AW'(wa); bus.s_data = DW'(wd);
        #1;
        ne  = qa.size() != 0;
        rdy = qa.size() < (1 << L2);
        if (be)                        win = 1;
        else if (ne && wait_m == MAXW) win = 2;
        else if (sr)                   win = 3;
        else if (ne)                   win = 2;
        else                           win = 0;
        chk("s_ready", bus.s_ready, rdy);
        chk("wfifo_level", bus.wfifo_level, qa.size());
        chk("spr_grant", bus.spr_grant, win == 3);
        chk("mem_en", bus.mem_en, win != 0);
        chk("mem_we", bus.mem_we, win == 2);
        if (win == 1) chk("mem_addr_bkg", bus.mem_addr, ba & 'h3FFF);
        if (win == 3) chk("mem_addr_spr", bus.mem_addr, sa & 'h3FFF);
        if (win == 2) begin
            chk("mem_addr_wr", bus.mem_addr, qa[0]);
            chk("mem_wdata", bus.mem_wdata, qd[0]);
        end
        chk("bkg_rvalid", bus.bkg_rvalid, tag_m == 1);
        chk("spr_rvalid", bus.spr_rvalid, tag_m == 2);
        if (tag_m == 1) chk("bkg_rdata", bus.bkg_rdata, rd_exp);
        if (tag_m == 2) chk("spr_rdata", bus.spr_rdata, rd_exp);
        // advance model to next cycle
        tag_m = (win == 1) ? 1 : (win == 3) ? 2 : 0;
        if (win == 1) rd_exp = mem_m(ba);
        if (win == 3) rd_exp = mem_m(sa);
        if (win == 2) begin
            shadow_delta[AW'(qa[0])] = DW'(qd[0]) ^ DW'(qa[0]) ^ 8'h5A;
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        if (!ne || win == 2)   wait_m = 0;
        else if (wait_m < MAXW) wait_m++;
        if (sv && rdy) begin
            qa.push_back(wa & 'h3FFF);
            qd.push_back(wd & 'hFF);
        end
        last_win = win;
    endtask

    task automatic set_idle();
        bus.bkg_en = 0; bus.bkg_addr = '0; bus.spr_req = 0; bus.spr_addr = '0;
        bus.s_valid = 0; bus.s_addr = '0; bus.s_data = '0;
    endtask

    task automatic apply_reset();
        #1 aresetn = 1'b0;
        qa.delete(); qd.delete();
        wait_m = 0; tag_m = 0; spr_pend = 0;
        #1;
        chk("rst_level", bus.wfifo_level, 0);
        chk("rst_ready", bus.s_ready, 1);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_bvalid", bus.bkg_rvalid, 0);
        chk("rst_svalid", bus.spr_rvalid, 0);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [4:0] exp_sv;
        set_idle();
        apply_reset();

        // background burst blocks a pending sprite
        for (int i = 0; i < 9; i++) begin
            step(i < 8, i, 1, 'h100, 0, 0, 0);
            if (i < 8) chk("s1_grant_blocked", bus.spr_grant, 0);
            else       chk("s1_grant_free", bus.spr_grant, 1);
            if (i >= 1) begin
                chk("s1_bvalid", bus.bkg_rvalid, 1);
                chk("s1_bdata", bus.bkg_rdata, (i - 1) ^ 'h5A);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("s1_svalid", bus.spr_rvalid, 1);
        chk("s1_sdata", bus.spr_rdata, 'h5A);

        // sprite interleaves with toggling background
        exp_sv = 5'b10100;
        for (int j = 0; j < 5; j++) begin
            step((j % 2) == 0 && j < 4, 'h10 + j, j < 4, 'h100, 0, 0, 0);
            chk("s2_grant", bus.spr_grant, (j % 2) == 1 && j < 4);
            chk("s2_svalid", bus.spr_rvalid, exp_sv[j]);
        end

        // FIFO fills under continuous background, then drains in order
        for (int k = 0; k < 5; k++) begin
            step(1, k, 0, 0, 1, 'h200 + k, 'hA0 + k);
            chk("s3_ready", bus.s_ready, k < 4);
        end
        for (int m = 0; m < 4; m++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("s3_we", bus.mem_we, 1);
            chk("s3_addr", bus.mem_addr, 'h200 + m);
            chk("s3_wdata", bus.mem_wdata, 'hA0 + m);
            chk("s3_ready_after", bus.s_ready, m >= 1);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("s3_empty", bus.wfifo_level, 0);

        // starvation limit: write beats sprites after MAXW lost cycles
        step(0, 0, 0, 0, 1, 'h2F0, 'h77);
        chk("s4_idle", bus.mem_en, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 1, 'h180, 0, 0, 0);
            chk("s4_grant", bus.spr_grant, k != 4);
            chk("s4_we", bus.mem_we, k == 4);
            if (k == 4) chk("s4_addr", bus.mem_addr, 'h2F0);
        end

        // simultaneous push/pop at level 2, then pointer wrap over 10 writes
        step(1, 5, 0, 0, 1, 'h301, 'h11);
        step(1, 6, 0, 0, 1, 'h302, 'h12);
        step(0, 0, 0, 0, 1, 'h303, 'h13);
        chk("s5_level", bus.wfifo_level, 2);
        chk("s5_addr0", bus.mem_addr, 'h301);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("s5_level_kept", bus.wfifo_level, 2);
        chk("s5_addr1", bus.mem_addr, 'h302);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("s5_addr2", bus.mem_addr, 'h303);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, 'h320 + k, 'hC0 + k);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k <= 10; k++) begin
            step(k < 10, 'h320 + k, 0, 0, 0, 0, 0);
            if (k >= 1) chk("s5_readback", bus.bkg_rdata, 'hC0 + k - 1);
        end

        // reset with queued writes and a granted sprite read
        step(1, 0, 0, 0, 1, 'h3A0, 'h01);
        step(1, 0, 0, 0, 1, 'h3A1, 'h02);
        step(1, 0, 0, 0, 1, 'h3A2, 'h03);
        step(0, 0, 1, 'h1C0, 0, 0, 0);
        chk("s6_grant", bus.spr_grant, 1);
        chk("s6_level", bus.wfifo_level, 3);
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("s6_no_we", bus.mem_we, 0);
            chk("s6_svalid", bus.spr_rvalid, 0);
        end
        step(1, 'h3A0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("s6_not_written", bus.bkg_rdata, 'hFA);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!spr_pend && $urandom_range(2) == 0) begin
                spr_pend = 1;
                spr_pend_addr = $urandom_range(31);
            end
            step($urandom_range(9) < 4, $urandom_range(31), spr_pend, spr_pend_addr,
                 $urandom_range(1), $urandom_range(31), $urandom_range(255));
            if (last_win == 3) spr_pend = 0;
            if ($urandom_range(499) == 0) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vram_access_arbiter.md
Name: vram_access_arbiter

Overview:
- Owns the single VRAM block-RAM port and shares it between three requesters:
  - background tile renderer pixel reads: hard real-time, never stalled;
  - sprite row fetcher reads: can wait;
  - bus writes: buffered in a small FIFO, applied in free cycles.
- Sits between the bus write interface / renderers and the VRAM array.
- Replaces the ad-hoc mux on the VRAM address with a defined priority, back-pressure and anti-starvation scheme.

Parameters:
- VRAM_ADDR_WIDTH, 14: VRAM word address width.
- VRAM_DATA_WIDTH, 8: VRAM word width.
- WFIFO_DEPTH_LOG2, 2: log2 of write FIFO depth (4 entries).
- WRITE_MAX_WAIT, 15: cycles a pending write may lose to sprite reads before it outranks them; 0 = writes always beat sprites.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- bkg_en  in  1  background read request; always granted
- bkg_addr  in  VRAM_ADDR_WIDTH  background read address
- bkg_rdata  out  VRAM_DATA_WIDTH  background read data
- bkg_rvalid  out  1  bkg_rdata valid (1 cycle after bkg_en)
- spr_req  in  1  sprite read request; held until granted
- spr_addr  in  VRAM_ADDR_WIDTH  sprite read address; stable while spr_req
- spr_grant  out  1  combinational; spr_req accepted this cycle
- spr_rdata  out  VRAM_DATA_WIDTH  sprite read data
- spr_rvalid  out  1  spr_rdata valid (1 cycle after grant)
- s_valid  in  1  bus write valid
- s_addr  in  VRAM_ADDR_WIDTH  bus write word address
- s_data  in  VRAM_DATA_WIDTH  bus write data
- s_ready  out  1  FIFO not full
- mem_en  out  1  VRAM port enable
- mem_we  out  1  VRAM write enable
- mem_addr  out  VRAM_ADDR_WIDTH  VRAM address
- mem_wdata  out  VRAM_DATA_WIDTH  VRAM write data
- mem_rdata  in  VRAM_DATA_WIDTH  VRAM read data, registered, 1-cycle latency
- wfifo_level  out  WFIFO_DEPTH_LOG2+1  FIFO occupancy

Behaviour:
- Reset state (async assert, sync-safe release): FIFO empty; wfifo_level=0; s_ready=1; bkg_rvalid=0; spr_rvalid=0; wait_cnt=0; rd_tag=none.
- Reset mid-operation drops queued writes and in-flight reads; no rvalid after release until a new request.
- Port select, combinational, one winner per cycle:
  - 1) bkg_en → background read;
  - 2) FIFO non-empty AND wait_cnt==WRITE_MAX_WAIT → write;
  - 3) spr_req → sprite read, spr_grant=1;
  - 4) FIFO non-empty → write;
  - 5) idle: mem_en=0, mem_we=0.
- spr_grant=0 whenever bkg_en=1.
- A write winner drives mem_en=1, mem_we=1, mem_addr/mem_wdata from the FIFO head, and pops the FIFO that cycle.
- A read winner drives mem_en=1, mem_we=0. rd_tag register records BKG/SPR/none.
- Next cycle: bkg_rvalid = (rd_tag==BKG), spr_rvalid = (rd_tag==SPR). Both rdata outputs are wired to mem_rdata. Exactly one rvalid at a time.
- Read latency: 1 cycle request→rvalid for both read clients.
- Write FIFO:
  - push when s_valid && s_ready; s_ready = (wfifo_level != 2**WFIFO_DEPTH_LOG2);
  - simultaneous push and pop keeps level unchanged;
  - pointers wrap modulo depth;
  - order preserved.
- Write latency: at least 1 cycle from push to mem write; a write pushed into an empty FIFO can be issued the next cycle at earliest.
- Read-after-write ordering is not enforced. A read may return pre-write data while the write is queued; software sequences accordingly.
- Starvation counter wait_cnt:
  - increments each cycle FIFO non-empty and no write issued, saturating at WRITE_MAX_WAIT;
  - clears on every write issue and when FIFO empty;
  - never overrides bkg_en: a write can stall indefinitely during continuous background reads and only ever blocks sprites.
- No combinational path from s_valid to s_ready.

Test Plan:
- bkg_en=1 for 8 cycles, addr 0..7, mem model data=addr^0x5A → bkg_rvalid 8 cycles, one cycle later, data 0x5A..0x5D...; spr_grant=0 throughout even with spr_req=1.
- spr_req=1 addr 0x100 with bkg_en toggling 1,0,1,0 → spr_grant only in bkg_en=0 cycles; spr_rvalid the next cycle; no double grant.
- bkg_en=1 continuously, 5 back-to-back s_valid writes → 4 accepted, s_ready=0 after the 4th, wfifo_level=4; drop bkg_en → writes issue in order, one per cycle, s_ready returns 1 after the first pop.
- WRITE_MAX_WAIT=3, spr_req held high, 1 write queued → sprite granted 3 cycles, write issued on the 4th, wait_cnt back to 0, sprite resumes.
- Level 2, simultaneous push and pop in an idle cycle → level stays 2, pushed entry lands at the wrapped tail; pointer wrap exercised over 10 writes with mem contents checked.
- Assert aresetn=0 with 3 queued writes and a granted sprite read → no mem_we after reset, wfifo_level=0, s_ready=1, spr_rvalid=0 next cycle.
